alu_exec_unit: RTL and testbench

Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder and performs the operation on the two register-file operands. Single-cycle operations complete with a registered result one cycle after issue. MULA (multiply-accumulate) runs on a multi-cycle iterative shift-add multiplier feeding a 2×WIDTH accumulator, and holds Busy to stall the pipeline until it completes.

---
 rtl/alu_exec_unit.sv | 184 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops with registered results, plus an
// iterative shift-add multiply-accumulate onto a double-width accumulator.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               InValid,
  input  logic [3:0]         ALUCtrl,
  input  logic [WIDTH-1:0]   BusA,
  input  logic [WIDTH-1:0]   BusB,
  input  logic [4:0]         Shamt,
  input  logic               AccClear,
  output logic [WIDTH-1:0]   ALUResult,
  output logic               Zero,
  output logic               Overflow,
  output logic               OutValid,
  output logic               Busy,
  output logic [2*WIDTH-1:0] AccOut
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_MULA = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_ADDU = 4'b1000;
  localparam logic [3:0] OP_SUBU = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_LUI  = 4'b1110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_ACC
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_sign;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_ovf;
  logic               r_valid;

  logic               w_accept;
  logic               w_is_mula;
  logic               w_last;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_res;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_acc_add;
  logic [2*WIDTH-1:0] w_acc_new;

  assign w_accept  = InValid && (r_state == S_IDLE);
  assign w_is_mula = (ALUCtrl == OP_MULA);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_sum     = BusA + BusB;
  assign w_diff    = BusA - BusB;
  assign w_abs_a   = BusA[WIDTH-1] ? -BusA : BusA;
  assign w_abs_b   = BusB[WIDTH-1] ? -BusB : BusB;
  assign w_acc_add = r_sign ? -r_prod : r_prod;
  assign w_acc_new = r_acc + w_acc_add;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    unique case (ALUCtrl)
      OP_AND:  w_res = BusA & BusB;
      OP_OR:   w_res = BusA | BusB;
      OP_XOR:  w_res = BusA ^ BusB;
      OP_NOR:  w_res = ~(BusA | BusB);
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (BusA[WIDTH-1] == BusB[WIDTH-1]) &&
                (w_sum[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = (BusA[WIDTH-1] != BusB[WIDTH-1]) &&
                (w_diff[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_ADDU: w_res = w_sum;
      OP_SUBU: w_res = w_diff;
      OP_SLT:  w_res = WIDTH'($signed(BusA) < $signed(BusB));
      OP_SLTU: w_res = WIDTH'(BusA < BusB);
      OP_SLL:  w_res = BusB << Shamt;
      OP_SRL:  w_res = BusB >> Shamt;
      OP_SRA:  w_res = $signed(BusB) >>> Shamt;
      OP_LUI:  w_res = {BusB[15:0], {(WIDTH-16){1'b0}}};
      default: w_res = '0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept && w_is_mula) w_next = S_MUL;
      S_MUL:   if (w_last) w_next = S_ACC;
      S_ACC:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (AccClear) r_acc <= '0;
          if (w_accept) begin
            if (w_is_mula) begin
              r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
              r_mplier <= w_abs_b;
              r_sign   <= BusA[WIDTH-1] ^ BusB[WIDTH-1];
              r_prod   <= '0;
              r_cnt    <= '0;
            end else begin
              r_result <= w_res;
              r_zero   <= (w_res == '0);
              r_ovf    <= w_ovf;
              r_valid  <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (r_mplier[0]) r_prod <= r_prod + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
        end
        S_ACC: begin
          r_acc    <= w_acc_new;
          r_result <= w_acc_new[WIDTH-1:0];
          r_zero   <= (w_acc_new[WIDTH-1:0] == '0);
          r_ovf    <= 1'b0;
          r_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ALUResult = r_result;
  assign Zero      = r_zero;
  assign Overflow  = r_ovf;
  assign OutValid  = r_valid;
  assign Busy      = (r_state != S_IDLE);
  assign AccOut    = r_acc;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table for single-cycle ops,
// hand sequences for multiply-accumulate, busy stalls and mid-op reset.
module tb_alu_exec_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        InValid = 1'b0;
  logic [3:0]  ALUCtrl = 4'h0;
  logic [31:0] BusA = '0;
  logic [31:0] BusB = '0;
  logic [4:0]  Shamt = '0;
  logic        AccClear = 1'b0;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        Overflow;
  logic        OutValid;
  logic        Busy;
  logic [63:0] AccOut;

  int checks = 0;
  int failures = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .Reset(Reset), .InValid(InValid), .ALUCtrl(ALUCtrl),
    .BusA(BusA), .BusB(BusB), .Shamt(Shamt), .AccClear(AccClear),
    .ALUResult(ALUResult), .Zero(Zero), .Overflow(Overflow),
    .OutValid(OutValid), .Busy(Busy), .AccOut(AccOut)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        z;
    logic        o;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive at a falling edge; return in the cycle after the accepting edge.
  task automatic issue(input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh,
                       input logic clr);
    @(negedge CLK);
    ALUCtrl = c; BusA = a; BusB = b; Shamt = sh;
    AccClear = clr; InValid = 1'b1;
    @(negedge CLK);
    InValid = 1'b0; AccClear = 1'b0;
  endtask

  task automatic mula(input string name, input logic [31:0] a,
                      input logic [31:0] b, input logic clr,
                      input logic noise, input logic [31:0] exp_res,
                      input logic [63:0] exp_acc);
    int busy_n;
    int extra_v;
    busy_n = 0;
    extra_v = 0;
    issue(4'b0101, a, b, 5'd0, clr);
    for (int i = 0; i < 100; i++) begin
      if (!Busy) break;
      busy_n++;
      if (OutValid) extra_v++;
      if (noise) begin
        ALUCtrl = 4'b0010; BusA = 32'd1; BusB = 32'd1;
        InValid = (i % 3 == 0);
      end
      @(negedge CLK);
    end
    InValid = 1'b0;
    chk({name, " busy_cycles"}, 64'(busy_n), 64'd33);
    chk({name, " extra_valid"}, 64'(extra_v), 64'd0);
    chk({name, " outvalid"}, 64'(OutValid), 64'd1);
    chk({name, " result"}, 64'(ALUResult), 64'(exp_res));
    chk({name, " zero"}, 64'(Zero), 64'(exp_res == 32'd0));
    chk({name, " ovf"}, 64'(Overflow), 64'd0);
    chk({name, " acc"}, AccOut, exp_acc);
    @(negedge CLK);
    chk({name, " pulse_end"}, 64'(OutValid), 64'd0);
    chk({name, " hold"}, 64'(ALUResult), 64'(exp_res));
  endtask

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{4'b0010, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b0, 1'b1};
    vecs[1]  = '{4'b1000, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b0, 1'b0};
    vecs[2]  = '{4'b0110, 32'h5, 32'h5, 5'd0, 32'h0, 1'b1, 1'b0};
    vecs[3]  = '{4'b0111, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 1'b0, 1'b0};
    vecs[4]  = '{4'b1011, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 1'b1, 1'b0};
    vecs[5]  = '{4'b1101, 32'h0, 32'h80000000, 5'd4, 32'hF8000000, 1'b0, 1'b0};
    vecs[6]  = '{4'b1110, 32'h0, 32'h1234, 5'd0, 32'h12340000, 1'b0, 1'b0};
    vecs[7]  = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 1'b0, 1'b0};
    vecs[8]  = '{4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hFFF0FFF0, 1'b0, 1'b0};
    vecs[9]  = '{4'b1010, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h0FF00FF0, 1'b0, 1'b0};
    vecs[10] = '{4'b1100, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h000F000F, 1'b0, 1'b0};
    vecs[11] = '{4'b0011, 32'h0, 32'h1, 5'd31, 32'h80000000, 1'b0, 1'b0};
    vecs[12] = '{4'b0100, 32'h0, 32'h80000000, 5'd31, 32'h1, 1'b0, 1'b0};
    vecs[13] = '{4'b0110, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[14] = '{4'b1001, 32'h0, 32'h1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[15] = '{4'b0010, 32'h1, 32'h2, 5'd0, 32'h3, 1'b0, 1'b0};
    vecs[16] = '{4'b1111, 32'h1234, 32'h5678, 5'd3, 32'h0, 1'b1, 1'b0};

    repeat (3) @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);
    chk("rst result", 64'(ALUResult), 64'd0);
    chk("rst zero", 64'(Zero), 64'd0);
    chk("rst ovf", 64'(Overflow), 64'd0);
    chk("rst valid", 64'(OutValid), 64'd0);
    chk("rst busy", 64'(Busy), 64'd0);
    chk("rst acc", AccOut, 64'd0);

    foreach (vecs[i]) begin
      issue(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].sh, 1'b0);
      chk($sformatf("v%0d valid", i), 64'(OutValid), 64'd1);
      chk($sformatf("v%0d result", i), 64'(ALUResult), 64'(vecs[i].res));
      chk($sformatf("v%0d zero", i), 64'(Zero), 64'(vecs[i].z));
      chk($sformatf("v%0d ovf", i), 64'(Overflow), 64'(vecs[i].o));
      chk($sformatf("v%0d busy", i), 64'(Busy), 64'd0);
    end
    chk("acc after alu ops", AccOut, 64'd0);

    mula("mula_neg", 32'hFFFFFFFD, 32'h7, 1'b1, 1'b0,
         32'hFFFFFFEB, 64'hFFFFFFFFFFFFFFEB);
    mula("mula_acc", 32'h5, 32'h5, 1'b0, 1'b0,
         32'h4, 64'h4);
    mula("mula_max", 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1,
         32'h1, 64'h3FFFFFFF00000001);

    issue(4'b1111, 32'hFFFF, 32'hFFFF, 5'd0, 1'b0);
    chk("undef valid", 64'(OutValid), 64'd1);
    chk("undef result", 64'(ALUResult), 64'd0);
    chk("undef zero", 64'(Zero), 64'd1);
    chk("undef acc", AccOut, 64'h3FFFFFFF00000001);

    issue(4'b0101, 32'h3, 32'h4, 5'd0, 1'b0);
    repeat (10) @(negedge CLK);
    chk("abort busy_before", 64'(Busy), 64'd1);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    chk("abort busy", 64'(Busy), 64'd0);
    chk("abort acc", AccOut, 64'd0);
    chk("abort valid", 64'(OutValid), 64'd0);
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge CLK);
        if (OutValid) pulses++;
      end
      chk("abort no_pulse", 64'(pulses), 64'd0);
    end
    issue(4'b0010, 32'd2, 32'd3, 5'd0, 1'b0);
    chk("post valid", 64'(OutValid), 64'd1);
    chk("post result", 64'(ALUResult), 64'd5);
    chk("post acc", AccOut, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
